// File: rtl/piso_shift_register_if.sv
// Load handshake and serial output bundle for piso_shift_register.
// The block drives the slave modport; a word source or bench uses the master modport.
interface piso_shift_register_if #(
   parameter int DEPTH = 4
) ();
   logic             load_valid;
   logic             load_ready;
   logic [DEPTH-1:0] load_data;
   logic             Q;
   logic             Q_valid;
   logic             last;
   logic             busy;

   modport master (
      output load_valid,
      output load_data,
      input  load_ready,
      input  Q,
      input  Q_valid,
      input  last,
      input  busy
   );

   modport slave (
      input  load_valid,
      input  load_data,
      output load_ready,
      output Q,
      output Q_valid,
      output last,
      output busy
   );
endinterface

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out shifter with valid/ready load and back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit after each data word.
//
// state  | meaning
// IDLE   | no frame in flight, ready for a word
// SHIFT  | driving data bits, cnt_q = index of the bit currently on Q
// PARITY | driving the parity bit (only with PISO_PARITY_EN)
module piso_shift_register #(
   parameter int DEPTH     = 4,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic           clk,
   input  logic           rst_n,
   piso_shift_register_if.slave bus
);
   localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

`ifdef PISO_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t           state_q, state_d;
   logic [DEPTH-1:0] sreg_q, sreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             q_q, q_d;
   logic             q_valid_q, q_valid_d;
   logic             last_q, last_d;
   logic             busy_q, busy_d;
`ifdef PISO_PARITY_EN
   logic             par_q, par_d;
`endif

   logic             load_ready;
   logic             accept;
   logic             do_load;
   logic [DEPTH-1:0] src;
   logic [DEPTH-1:0] src_shift;
   logic             src_bit;

`ifdef PISO_PARITY_EN
   assign load_ready = (state_q == IDLE) || (state_q == PARITY);
`else
   assign load_ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == CNT_LAST));
`endif
   assign accept = bus.load_valid && load_ready;

   // The first bit of a freshly accepted word goes straight to Q, so the
   // register only ever holds the bits still to be sent.
   always_comb begin
      src = accept ? bus.load_data : sreg_q;
      if (LSB_FIRST) begin
         src_bit   = src[0];
         src_shift = src >> 1;
      end else begin
         src_bit   = src[DEPTH-1];
         src_shift = src << 1;
      end
   end

   always_comb begin
      state_d   = state_q;
      sreg_d    = sreg_q;
      cnt_d     = cnt_q;
      q_d       = 1'b0;
      q_valid_d = 1'b0;
      last_d    = 1'b0;
      busy_d    = 1'b0;
      do_load   = 1'b0;
`ifdef PISO_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (accept) do_load = 1'b1;
         end
         SHIFT: begin
            if (cnt_q != CNT_LAST) begin
               sreg_d    = src_shift;
               q_d       = src_bit;
               cnt_d     = cnt_q + CW'(1);
               q_valid_d = 1'b1;
               busy_d    = 1'b1;
`ifdef PISO_PARITY_EN
               last_d    = 1'b0;
`else
               last_d    = (cnt_d == CNT_LAST);
`endif
            end else begin
`ifdef PISO_PARITY_EN
               state_d   = PARITY;
               q_d       = par_q;
               q_valid_d = 1'b1;
               last_d    = 1'b1;
               busy_d    = 1'b1;
`else
               if (accept) do_load = 1'b1;
               else state_d = IDLE;
`endif
            end
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            if (accept) do_load = 1'b1;
            else state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase

      if (do_load) begin
         state_d   = SHIFT;
         sreg_d    = src_shift;
         q_d       = src_bit;
         cnt_d     = '0;
         q_valid_d = 1'b1;
         busy_d    = 1'b1;
         last_d    = 1'b0;
`ifdef PISO_PARITY_EN
         par_d     = ^bus.load_data;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sreg_q    <= '0;
         cnt_q     <= '0;
         q_q       <= 1'b0;
         q_valid_q <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef PISO_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         sreg_q    <= sreg_d;
         cnt_q     <= cnt_d;
         q_q       <= q_d;
         q_valid_q <= q_valid_d;
         last_q    <= last_d;
         busy_q    <= busy_d;
`ifdef PISO_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign bus.load_ready = load_ready;
   assign bus.Q          = q_q;
   assign bus.Q_valid    = q_valid_q;
   assign bus.last       = last_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench for piso_shift_register: one MSB-first and one LSB-first instance,
// expectations follow PISO_PARITY_EN when it is defined for the build.
module tb_piso_shift_register;
`ifdef PISO_PARITY_EN
   localparam int FL = 5;
`else
   localparam int FL = 4;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   piso_shift_register_if #(.DEPTH(4)) if0 ();
   piso_shift_register_if #(.DEPTH(4)) if1 ();

   piso_shift_register #(.DEPTH(4), .LSB_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   piso_shift_register #(.DEPTH(4), .LSB_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic got, input logic exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s observed=%b expected=%b", tag, got, exp);
   endtask

   task automatic chk_out(input string tag, input bit sel,
                          input logic q, input logic qv, input logic l,
                          input logic b, input logic lr);
      chk({tag, ".Q"},          sel ? if1.Q          : if0.Q,          q);
      chk({tag, ".Q_valid"},    sel ? if1.Q_valid    : if0.Q_valid,    qv);
      chk({tag, ".last"},       sel ? if1.last       : if0.last,       l);
      chk({tag, ".busy"},       sel ? if1.busy       : if0.busy,       b);
      chk({tag, ".load_ready"}, sel ? if1.load_ready : if0.load_ready, lr);
   endtask

   // Builds the transmit-order bit vector: data bits then (if compiled in) parity.
   function automatic logic [4:0] fb(input logic [3:0] w, input logic p);
`ifdef PISO_PARITY_EN
      return {w, p};
`else
      if (p) return {1'b0, w};
      return {1'b0, w};
`endif
   endfunction

   // Called just after the accepting edge; ends sitting on the frame's last cycle.
   // pulse_at >= 0 raises load_valid with 0000 for one edge after that bit.
   task automatic frame_chk(input string tag, input bit sel, input logic [4:0] bits, input int pulse_at);
      for (int i = 0; i < FL; i++) begin
         chk_out($sformatf("%s.b%0d", tag, i), sel, bits[FL-1-i], 1'b1,
                 (i == FL-1), 1'b1, (i == FL-1));
         if (i < FL-1) begin
            if (i == pulse_at) begin
               if0.load_valid = 1'b1;
               if0.load_data  = 4'b0000;
            end
            tick();
            if (i == pulse_at) if0.load_valid = 1'b0;
         end
      end
   endtask

   initial begin
      if0.load_valid = 1'b0;
      if0.load_data  = 4'b0000;
      if1.load_valid = 1'b0;
      if1.load_data  = 4'b0000;

      // reset values held for three cycles, then released
      #1;
      chk_out("rst0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      rst_n = 1'b1;
      tick();
      chk_out("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk_out("idle1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // MSB-first single frame 1011, parity 1
      if0.load_valid = 1'b1; if0.load_data = 4'b1011;
      tick();
      if0.load_valid = 1'b0;
      frame_chk("msb1011", 1'b0, fb(4'b1011, 1'b1), -1);
      tick();
      chk_out("post1011", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // back-to-back 1100 then 0110 offered on the last cycle
      if0.load_valid = 1'b1; if0.load_data = 4'b1100;
      tick();
      if0.load_valid = 1'b0;
      frame_chk("b2b_a", 1'b0, fb(4'b1100, 1'b0), -1);
      if0.load_valid = 1'b1; if0.load_data = 4'b0110;
      tick();
      if0.load_valid = 1'b0;
      frame_chk("b2b_b", 1'b0, fb(4'b0110, 1'b0), -1);
      tick();
      chk_out("post_b2b", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // LSB-first 1000 transmits 0,0,0,1; parity 1
      if1.load_valid = 1'b1; if1.load_data = 4'b1000;
      tick();
      if1.load_valid = 1'b0;
      frame_chk("lsb1000", 1'b1, fb(4'b0001, 1'b1), -1);
      tick();
      chk_out("post_lsb", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // load 1111, pulse 0000 during bit 2 -> ignored
      if0.load_valid = 1'b1; if0.load_data = 4'b1111;
      tick();
      if0.load_valid = 1'b0;
      frame_chk("busy1111", 1'b0, fb(4'b1111, 1'b0), 1);
      tick();
      chk_out("post1111", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // reset during bit 3 of frame 1010 aborts at once
      if0.load_valid = 1'b1; if0.load_data = 4'b1010;
      tick();
      if0.load_valid = 1'b0;
      chk_out("abort.b0", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("abort.b1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      chk_out("abort.b2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("abort.now", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      chk_out("abort.hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // release reset together with a load: accepted on the first edge
      rst_n = 1'b1;
      if0.load_valid = 1'b1; if0.load_data = 4'b0110;
      tick();
      if0.load_valid = 1'b0;
      frame_chk("postrst0110", 1'b0, fb(4'b0110, 1'b0), -1);
      tick();
      chk_out("post0110", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // 1001 has even parity 0
      if0.load_valid = 1'b1; if0.load_data = 4'b1001;
      tick();
      if0.load_valid = 1'b0;
      frame_chk("msb1001", 1'b0, fb(4'b1001, 1'b0), -1);
      tick();
      chk_out("post1001", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
